updown_step_arbiter: RTL and testbench
======================================

# updown_step_arbiter

Round-robin arbiter and sequencer that shares one up/down step counter between two requesters (e.g. two debounced pushbutton or encoder channels). Each requester asks for a single up or down step; the block grants one requester at a time, applies exactly one step per request to the shared count, and acknowledges it. It sits between the input-conditioning logic and the count display/decoder, owning the count register.

## Interface
- `WIDTH`, 3, count width in bits
- `MAX_COUNT`, 7, highest legal count value; must satisfy 1 ≤ MAX_COUNT ≤ 2^WIDTH−1
- `clk`  input  1  single clock; all state updates on rising edge
- `reset`  input  1  asynchronous, active-high reset
- `req`  input  2  per-requester step request, level; bit i = requester i
- `dir`  input  2  per-requester direction, 1 = up, 0 = down; sampled with `req[i]` at grant
- `ack`  output  2  one-cycle pulse on bit g when requester g's step is applied
- `grant`  output  2  one-hot current owner, high from grant through release; 0 when idle
- `busy`  output  1  high whenever state ≠ IDLE
- `step`  output  1  one-cycle pulse, coincident with `ack`, when the count changes or a step is attempted
- `up_down`  output  1  latched direction of current/last granted step
- `count`  output  WIDTH  shared count value
- `limit`  output  1  one-cycle pulse when a step is blocked at a bound (see Configuration)

## Operation
- Reset values: state IDLE, `count`=0, `ack`=0, `grant`=0, `busy`=0, `step`=0, `up_down`=0, `limit`=0, last-served pointer = 1 (requester 0 wins the first tie).
- States: IDLE, STEP, HOLD.
- IDLE: if no `req`, stay. If one `req` bit set, grant it. If both set, grant the requester not last served. Latch `dir[g]` into `up_down`, set `grant`, update last-served pointer to g, go to STEP.
- STEP: apply one step to `count`, pulse `ack[g]` and `step`, go to HOLD. Always exactly one cycle.
- HOLD: keep `grant`; wait for `req[g]`=0, then clear `grant` and go to IDLE. A requester that keeps `req` high gets no further steps. It must drop and re-raise `req` to step again.
- `dir` changes after grant are ignored for that step. `req` of the non-granted requester is held pending and is served on the next IDLE.
- Arithmetic, default build (wrap): up at MAX_COUNT → 0; down at 0 → MAX_COUNT; otherwise ±1. Results never exceed MAX_COUNT.
- Asynchronous `reset` mid-operation (any state) immediately forces all reset values. A pending step is discarded with no `ack`.

## Timing
- `req[i]` first seen high at edge k (IDLE): `grant`/`busy`/`up_down` valid after edge k.
- New `count`, `ack`, and `step` are valid after edge k+1. `ack`/`step` drop after edge k+2.
- Minimum request-to-count latency: 2 cycles.
- `req[g]` low seen at edge m in HOLD: `grant`=0 and `busy`=0 after edge m.
- Earliest next grant is at edge m+1, so back-to-back service takes ≥3 cycles per step.
- All outputs are registered; there are no combinational input-to-output paths.

## Configuration
- `COUNT_SAT_EN` defined: saturating mode. An up step at MAX_COUNT or a down step at 0 leaves `count` unchanged. In that STEP cycle `limit` pulses for one cycle. `ack` and `step` still pulse.
- `COUNT_SAT_EN` undefined: wrap mode as in Operation. `limit` is tied to 0.

## Test plan
- Reset then single request: `req`=01, `dir`=01, hold 5 cycles → `count` 0→1 two cycles after sampling; `ack[0]` high for exactly 1 cycle; no second step while `req[0]` stays high.
- Simultaneous requests after reset: `req`=11, `dir`=10, each requester dropping `req` after its ack → requester 0 served first (`count` 0→7 wrap), then requester 1 (7→0). `grant` goes 01 then 10.
- Fairness: both requesters re-raise `req` immediately after each release for 6 rounds → grants strictly alternate; final `count` equals (#up − #down) mod (MAX_COUNT+1).
- Wrap boundary, default build: 8 up steps from 0 → `count` returns to 0 and `limit` never asserts. With `COUNT_SAT_EN`, 9 up steps → `count` holds 7 and `limit` pulses once on the 8th and once on the 9th step.
- Reset in STEP: assert `reset` asynchronously mid-cycle during STEP → outputs are immediately at reset values with no `ack` pulse; after reset release, `req` still high starts a fresh grant.
- `dir` change after grant: `req[1]`=1 with `dir[1]`=1, flip `dir[1]` to 0 one cycle later → `count` increments by 1 and `up_down`=1.

Source files
------------

// File: rtl/updown_step_arbiter_if.sv
// rtl/updown_step_arbiter_if.sv - request/step bundle between requesters and the shared step counter
//
// Purpose: groups the two-requester handshake and the counter-side outputs of
// updown_step_arbiter into one bundle.
//
// Signals:
//   req[1:0]      requester -> arbiter, level step request, bit i = requester i
//   dir[1:0]      requester -> arbiter, 1 = up, 0 = down, captured at grant
//   ack[1:0]      arbiter -> requester, one-cycle pulse when that step lands
//   grant[1:0]    arbiter -> requester, one-hot owner from grant until release
//   busy          arbiter -> observer, high whenever the arbiter is not idle
//   step          arbiter -> observer, one-cycle pulse coincident with ack
//   up_down       arbiter -> observer, direction of the current/last step
//   count[W-1:0]  arbiter -> display, shared count value
//   limit         arbiter -> observer, pulse when a step is blocked at a bound
//
// Modports:
//   master  requester / testbench side (drives req, dir)
//   slave   arbiter side (drives everything else)

interface updown_step_arbiter_if #(
    parameter int WIDTH = 3
);
    logic [1:0]       req;
    logic [1:0]       dir;
    logic [1:0]       ack;
    logic [1:0]       grant;
    logic             busy;
    logic             step;
    logic             up_down;
    logic [WIDTH-1:0] count;
    logic             limit;

    modport master (
        output req,
        output dir,
        input  ack,
        input  grant,
        input  busy,
        input  step,
        input  up_down,
        input  count,
        input  limit
    );

    modport slave (
        input  req,
        input  dir,
        output ack,
        output grant,
        output busy,
        output step,
        output up_down,
        output count,
        output limit
    );
endinterface

// File: rtl/updown_step_arbiter.sv
// rtl/updown_step_arbiter.sv - two-requester round-robin arbiter owning a shared up/down step counter
//
// Purpose: grants one of two requesters at a time, applies exactly one up or
// down step per request to the shared count, and acknowledges it. A requester
// holding req high after its step gets nothing more until it drops and
// re-raises req. On a tie, the requester not served last wins.
//
// Parameters:
//   WIDTH      count width in bits
//   MAX_COUNT  highest legal count value, 1 <= MAX_COUNT <= 2**WIDTH-1
//
// Ports:
//   clk    single clock, rising edge
//   reset  asynchronous, active-high reset
//   bus    updown_step_arbiter_if.slave: req/dir in; ack, grant, busy, step,
//          up_down, count, limit out (all registered)
//
// Build option:
//   COUNT_SAT_EN  when defined, steps saturate at 0 / MAX_COUNT and pulse
//                 limit; otherwise the count wraps and limit stays 0.

module updown_step_arbiter #(
    parameter int WIDTH     = 3,
    parameter int MAX_COUNT = 7
) (
    input  logic                  clk,
    input  logic                  reset,
    updown_step_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        STEP = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] MAX_C = WIDTH'(MAX_COUNT);
    localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);

    state_t           state_q, state_d;
    logic             owner_q, owner_d;     // index of the granted requester
    logic             last_q,  last_d;      // index of the requester served last
    logic [1:0]       grant_q, grant_d;
    logic [1:0]       ack_q,   ack_d;
    logic             step_q,  step_d;
    logic             up_down_q, up_down_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic             limit_q, limit_d;

    logic             pick;                 // requester chosen if we grant this cycle
    logic             at_top;
    logic             at_bot;
    logic             blocked;              // step would cross a bound (saturating only)
    logic [WIDTH-1:0] stepped;              // count after applying the latched step

    // Single request: take it. Both requesting: the one not served last.
    // last_q resets to 1 so requester 0 wins the very first tie.
    assign pick = (bus.req == 2'b11) ? ~last_q : bus.req[1];

    assign at_top = (count_q == MAX_C);
    assign at_bot = (count_q == '0);

`ifdef COUNT_SAT_EN
    always_comb begin
        blocked = up_down_q ? at_top : at_bot;
        if (blocked) begin
            stepped = count_q;
        end else if (up_down_q) begin
            stepped = count_q + ONE;
        end else begin
            stepped = count_q - ONE;
        end
    end
`else
    always_comb begin
        blocked = 1'b0;
        if (up_down_q) begin
            stepped = at_top ? '0 : (count_q + ONE);
        end else begin
            stepped = at_bot ? MAX_C : (count_q - ONE);
        end
    end
`endif

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        last_d    = last_q;
        grant_d   = grant_q;
        ack_d     = 2'b00;
        step_d    = 1'b0;
        up_down_d = up_down_q;
        count_d   = count_q;
        limit_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.req != 2'b00) begin
                    owner_d   = pick;
                    last_d    = pick;
                    grant_d   = pick ? 2'b10 : 2'b01;
                    // Direction is frozen here; later dir changes do not
                    // affect this step.
                    up_down_d = bus.dir[pick];
                    state_d   = STEP;
                end
            end

            STEP: begin
                count_d = stepped;
                ack_d   = grant_q;
                step_d  = 1'b1;
                limit_d = blocked;
                state_d = HOLD;
            end

            HOLD: begin
                // Wait for the owner to release; the other requester's
                // req stays pending and is arbitrated once back in IDLE.
                if (!bus.req[owner_q]) begin
                    grant_d = 2'b00;
                    state_d = IDLE;
                end
            end

            default: begin
                grant_d = 2'b00;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            owner_q   <= 1'b0;
            last_q    <= 1'b1;
            grant_q   <= 2'b00;
            ack_q     <= 2'b00;
            step_q    <= 1'b0;
            up_down_q <= 1'b0;
            count_q   <= '0;
            limit_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            last_q    <= last_d;
            grant_q   <= grant_d;
            ack_q     <= ack_d;
            step_q    <= step_d;
            up_down_q <= up_down_d;
            count_q   <= count_d;
            limit_q   <= limit_d;
        end
    end

    assign bus.ack     = ack_q;
    assign bus.grant   = grant_q;
    assign bus.busy    = (state_q != IDLE);
    assign bus.step    = step_q;
    assign bus.up_down = up_down_q;
    assign bus.count   = count_q;
    assign bus.limit   = limit_q;

endmodule

// File: tb/tb_updown_step_arbiter.sv
// tb/tb_updown_step_arbiter.sv - self-checking bench for updown_step_arbiter

module tb_updown_step_arbiter;

    localparam int WIDTH = 3;
    localparam int MAXC  = 7;

    logic clk;
    logic reset;

    updown_step_arbiter_if #(.WIDTH(WIDTH)) bus ();

    updown_step_arbiter #(.WIDTH(WIDTH), .MAX_COUNT(MAXC)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: who owns the counter, how many cycles since grant,
    // and the count as a plain integer.
    int         m_owner;
    int         m_age;
    int         m_count;
    int         m_last;
    int         m_ud;
    int         mg;
    logic [1:0] e_ack;
    logic       e_step;
    logic       e_limit;
    int         ack_pulses [2];
    int         limit_pulses;

    initial begin
        m_owner = -1; m_age = 0; m_count = 0; m_last = 1; m_ud = 0;
        e_ack = 2'b00; e_step = 1'b0; e_limit = 1'b0;
        ack_pulses[0] = 0; ack_pulses[1] = 0; limit_pulses = 0;
    end

    always @(posedge clk) begin
        if (reset) begin
            m_owner = -1; m_age = 0; m_count = 0; m_last = 1; m_ud = 0;
            e_ack = 2'b00; e_step = 1'b0; e_limit = 1'b0;
        end else begin
            e_ack = 2'b00; e_step = 1'b0; e_limit = 1'b0;
            if (m_owner < 0) begin
                if (bus.req != 2'b00) begin
                    if (bus.req == 2'b11) mg = 1 - m_last;
                    else                  mg = bus.req[1] ? 1 : 0;
                    m_owner = mg;
                    m_last  = mg;
                    m_ud    = bus.dir[mg] ? 1 : 0;
                    m_age   = 0;
                end
            end else if (m_age == 0) begin
`ifdef COUNT_SAT_EN
                if ((m_ud == 1 && m_count == MAXC) || (m_ud == 0 && m_count == 0))
                    e_limit = 1'b1;
                else
                    m_count = m_count + (m_ud == 1 ? 1 : -1);
`else
                m_count = (m_count + (m_ud == 1 ? 1 : MAXC)) % (MAXC + 1);
`endif
                e_ack  = (m_owner == 1) ? 2'b10 : 2'b01;
                e_step = 1'b1;
                m_age  = 1;
            end else if (!bus.req[m_owner]) begin
                m_owner = -1;
            end
        end
        #1;
        chk("ack",     int'(bus.ack),     int'(e_ack));
        chk("grant",   int'(bus.grant),   (m_owner < 0) ? 0 : (1 << m_owner));
        chk("busy",    int'(bus.busy),    (m_owner < 0) ? 0 : 1);
        chk("step",    int'(bus.step),    int'(e_step));
        chk("up_down", int'(bus.up_down), m_ud);
        chk("count",   int'(bus.count),   m_count);
        chk("limit",   int'(bus.limit),   int'(e_limit));
        if (bus.ack[0]) ack_pulses[0]++;
        if (bus.ack[1]) ack_pulses[1]++;
        if (bus.limit)  limit_pulses++;
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset   = 1'b1;
        bus.req = 2'b00;
        bus.dir = 2'b00;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic wait_ack(input string name, output logic [1:0] a);
        a = 2'b00;
        for (int n = 0; n < 20; n++) begin
            tick();
            if (bus.ack != 2'b00) begin
                a = bus.ack;
                break;
            end
        end
        if (a == 2'b00) chk({name, "_timeout"}, 0, 1);
    endtask

    logic [1:0] a;
    int         a0;
    int         l0;
    int         expv;
    int         prev;
    int         g;
    logic       dv [2];

    initial begin
        reset   = 1'b1;
        bus.req = 2'b00;
        bus.dir = 2'b00;
        #1;
        chk("rst_count", int'(bus.count), 0);
        chk("rst_grant", int'(bus.grant), 0);
        chk("rst_busy",  int'(bus.busy),  0);
        chk("rst_ack",   int'(bus.ack),   0);
        chk("rst_limit", int'(bus.limit), 0);
        do_reset();

        // Single request held for several cycles: exactly one step.
        bus.req = 2'b01;
        bus.dir = 2'b01;
        a0 = ack_pulses[0];
        tick();
        chk("t1_grant", int'(bus.grant), 1);
        chk("t1_busy",  int'(bus.busy),  1);
        chk("t1_count_before", int'(bus.count), 0);
        tick();
        chk("t1_count", int'(bus.count), 1);
        chk("t1_ack",   int'(bus.ack),   1);
        chk("t1_step",  int'(bus.step),  1);
        repeat (3) tick();
        chk("t1_count_held", int'(bus.count), 1);
        chk("t1_one_ack", ack_pulses[0] - a0, 1);
        chk("t1_grant_held", int'(bus.grant), 1);
        @(negedge clk);
        bus.req = 2'b00;
        tick();
        chk("t1_release_grant", int'(bus.grant), 0);
        chk("t1_release_busy",  int'(bus.busy),  0);

        // Simultaneous requests: requester 0 first (down, wraps to 7).
        do_reset();
        bus.req = 2'b11;
        bus.dir = 2'b10;
        wait_ack("t2a", a);
        chk("t2_first",  int'(a), 1);
        chk("t2_grant0", int'(bus.grant), 1);
        chk("t2_count7", int'(bus.count), 7);
        @(negedge clk);
        bus.req[0] = 1'b0;
        wait_ack("t2b", a);
        chk("t2_second", int'(a), 2);
        chk("t2_grant1", int'(bus.grant), 2);
        chk("t2_count0", int'(bus.count), 0);
        @(negedge clk);
        bus.req[1] = 1'b0;

        // Fairness: both re-raise right after release; grants alternate.
        do_reset();
        dv[0] = 1'($urandom);
        dv[1] = 1'($urandom);
        bus.dir = {dv[1], dv[0]};
        bus.req = 2'b11;
        expv = 0;
        prev = -1;
        for (int r = 0; r < 12; r++) begin
            wait_ack("fair", a);
            if (a == 2'b00) break;
            g = a[1] ? 1 : 0;
            if (prev >= 0) chk("fair_alternate", g, 1 - prev);
            else           chk("fair_first", g, 0);
            expv += dv[g] ? 1 : -1;
            prev = g;
            @(negedge clk);
            bus.req[g] = 1'b0;
            @(negedge clk);
            if (r < 10) begin
                dv[g] = 1'($urandom);
                bus.dir[g] = dv[g];
                bus.req[g] = 1'b1;
            end
        end
        repeat (4) tick();
        chk("fair_count", int'(bus.count), ((expv % (MAXC + 1)) + (MAXC + 1)) % (MAXC + 1));
        chk("fair_idle", int'(bus.busy), 0);

        // Upper boundary: wrap in the default build, saturate otherwise.
        do_reset();
        l0 = limit_pulses;
`ifdef COUNT_SAT_EN
        for (int i = 0; i < 9; i++) begin
`else
        for (int i = 0; i < 8; i++) begin
`endif
            @(negedge clk);
            bus.req = 2'b01;
            bus.dir = 2'b01;
            wait_ack("bound", a);
            @(negedge clk);
            bus.req = 2'b00;
            @(negedge clk);
        end
        tick();
`ifdef COUNT_SAT_EN
        chk("sat_count", int'(bus.count), 7);
        chk("sat_limits", limit_pulses - l0, 2);
`else
        chk("wrap_count", int'(bus.count), 0);
        chk("wrap_limits", limit_pulses - l0, 0);
`endif

        // Asynchronous reset while in STEP discards the pending step.
        do_reset();
        bus.req = 2'b01;
        bus.dir = 2'b01;
        a0 = ack_pulses[0];
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("rstep_count", int'(bus.count), 0);
        chk("rstep_grant", int'(bus.grant), 0);
        chk("rstep_busy",  int'(bus.busy),  0);
        chk("rstep_ack",   int'(bus.ack),   0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        chk("rstep_no_ack", ack_pulses[0] - a0, 0);
        wait_ack("rstep_fresh", a);
        chk("rstep_fresh_ack", int'(a), 1);
        chk("rstep_fresh_count", int'(bus.count), 1);
        @(negedge clk);
        bus.req = 2'b00;

        // Direction change after grant is ignored for that step.
        do_reset();
        bus.req = 2'b10;
        bus.dir = 2'b10;
        @(posedge clk);
        @(negedge clk);
        bus.dir = 2'b00;
        wait_ack("dirchg", a);
        chk("dirchg_ack",   int'(a), 2);
        chk("dirchg_count", int'(bus.count), 1);
        chk("dirchg_ud",    int'(bus.up_down), 1);
        @(negedge clk);
        bus.req = 2'b00;

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            bus.req = 2'($urandom);
            bus.dir = 2'($urandom);
        end
        @(negedge clk);
        bus.req = 2'b00;
        repeat (5) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
